grid_frame_sequencer: RTL and testbench
=======================================

Name: grid_frame_sequencer

Overview:
- Sequences every write into the 16x16 game-grid memory once per game tick: clears the board, draws the food cell, then draws each snake segment from the packed snake vector.
- Sits between the Snake logic (snake vector, length, food coordinates, slow tick) and the memory write port (x_loc_sw, y_loc_sw, data_in, writeEnable).
- Replaces free-running snakeWriter writes, so the board holds no stale segments after the snake moves.

Parameters:
- GRID_W, 16, cells per row; x counter wraps at GRID_W-1.
- GRID_H, 16, rows; y counter wraps at GRID_H-1.
- MAX_SEG, 10, snake segments packed in the snake vector.
- COORD_W, 4, width of each x/y coordinate.

Ports:
- clk  input  1  system clock (25 MHz pixel clock domain).
- reset  input  1  synchronous, active-high reset.
- tick  input  1  game-step request, one clk cycle wide (rising edge of slow_clk, detected upstream).
- snake  input  MAX_SEG*2*COORD_W (80)  segment i = bits [8i+7:8i], x = [8i+7:8i+4], y = [8i+3:8i]; segment 0 is the head.
- snake_len  input  4  number of valid segments.
- xfood  input  COORD_W  food x coordinate.
- yfood  input  COORD_W  food y coordinate.
- wr_en  output  1  memory write strobe.
- wr_x  output  COORD_W  write x address.
- wr_y  output  COORD_W  write y address.
- wr_data  output  2  cell code: 00 empty, 01 body, 10 head, 11 food.
- busy  output  1  high while a frame sequence is in progress.
- done  output  1  one-cycle pulse when a sequence completes.
- overrun  output  1  sticky; a tick was lost.

Behaviour:
- All outputs are registered. Reset values: wr_en=0, wr_x=0, wr_y=0, wr_data=00, busy=0, done=0, overrun=0, state=IDLE, pending=0.
- States: IDLE, CLEAR, FOOD, SNAKE, DONE.
- IDLE: on tick=1 or pending=1 at a clk edge:
  - capture snake, snake_len, xfood and yfood into shadow registers;
  - clamp the captured length to MAX_SEG;
  - clear pending;
  - go to CLEAR.
- First write appears the cycle after the tick is sampled.
- CLEAR: one write per cycle with wr_data=00.
  - x increments every cycle; at GRID_W-1, x wraps to 0 and y increments.
  - After (GRID_W-1, GRID_H-1) is written, go to FOOD. That is exactly GRID_W*GRID_H = 256 writes.
- FOOD: one write at (captured xfood, captured yfood) with data 11.
  - Next state is SNAKE if captured len>0, else DONE.
- SNAKE: one write per cycle for segment k = 0 .. len-1.
  - Data is 10 for k=0 and 01 otherwise.
  - After segment len-1, go to DONE.
- DONE: wr_en=0, done=1 for exactly one cycle, then IDLE.
- Total busy cycles per sequence = 256 + 1 + len + 1.
- busy=1 in every state except IDLE. wr_en=1 only in CLEAR, FOOD and SNAKE.
- Tick while busy:
  - if pending=0, set pending=1 (served right after DONE, with one IDLE cycle between);
  - if pending=1 already, the tick is dropped and overrun is set to 1.
- overrun clears only on reset.
- Inputs are not sampled mid-sequence; changes to snake/food during busy have no effect on the current frame.
- Overlap: the snake is written after the food, so a segment on the food cell leaves 10 or 01 there. Duplicate segment coordinates are simply rewritten.
- Coordinates are used as-is, with no range check. COORD_W=4 covers the full grid.
- Reset asserted mid-sequence: in the next cycle wr_en=0, state=IDLE and pending=0. No partial-write completion.
- Snake length counter is 4 bits. Clamp compare: len > MAX_SEG gives MAX_SEG.

Test Plan:
- Reset, then a single tick with snake_len=3, segments (5,5),(4,5),(3,5), food (9,2):
  - writes 1..256 go to (0,0)..(15,15) with data 00;
  - write 257 is (9,2)=11;
  - then (5,5)=10, (4,5)=01, (3,5)=01;
  - done pulses 1 cycle after the last write; busy spans 261 cycles.
- snake_len=0 -> 256 clears plus the food write, then done. No 10/01 writes.
- snake_len=15 -> clamped to 10 segment writes; busy=268 cycles.
- Head on food, both at (7,7) -> (7,7) written 11, then overwritten with 10.
- Two ticks during busy:
  - first tick -> pending; a second sequence starts 1 IDLE cycle after done, with overrun=0;
  - a third tick before the second sequence starts -> overrun=1, which persists until reset.
- Reset asserted at write 100 of CLEAR -> next cycle wr_en=0, busy=0. A new tick restarts at (0,0).

Source files
------------

// File: rtl/grid_frame_sequencer.sv
// grid_frame_sequencer
//   Once per game tick, emits every write needed to redraw the game grid:
//   a full clear (all cells empty), the food cell, then each snake segment
//   from the head backwards. All inputs are snapshotted at sequence start.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   tick           one-cycle game-step request
//   snake          packed segments, segment i = [8i+7:8i], x high nibble, y low
//   snake_len      number of valid segments (clamped to MAX_SEG)
//   xfood, yfood   food coordinates
//   wr_en          memory write strobe
//   wr_x, wr_y     write address
//   wr_data        cell code: 00 empty, 01 body, 10 head, 11 food
//   busy           high while a frame sequence is in progress
//   done           one-cycle pulse at sequence completion
//   overrun        sticky flag, a tick was lost
module grid_frame_sequencer #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int MAX_SEG = 10,
  parameter int COORD_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [MAX_SEG*2*COORD_W-1:0] snake,
  input  logic [3:0]                   snake_len,
  input  logic [COORD_W-1:0]           xfood,
  input  logic [COORD_W-1:0]           yfood,
  output logic                         wr_en,
  output logic [COORD_W-1:0]           wr_x,
  output logic [COORD_W-1:0]           wr_y,
  output logic [1:0]                   wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int SEG_W = 2 * COORD_W;
  localparam int LEN_W = 4;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_SEG);

  typedef enum logic [2:0] {IDLE, CLEAR, FOOD, SNAKE, DONE} state_t;

  state_t                       state, state_n;
  logic                         pending, pending_n;
  logic                         overrun_n;
  logic                         capture;
  logic [LEN_W-1:0]             k, k_n;
  logic                         wr_en_n, done_n;
  logic [COORD_W-1:0]           x_n, y_n;
  logic [1:0]                   data_n;

  logic [MAX_SEG*SEG_W-1:0]     snake_q;
  logic [LEN_W-1:0]             len_q;
  logic [COORD_W-1:0]           xf_q, yf_q;

  logic [LEN_W-1:0]             seg_sel;
  logic [SEG_W-1:0]             seg;

  // Segment that will be presented next: the head when leaving FOOD,
  // otherwise the one after the segment currently on the bus.
  assign seg_sel = (state == SNAKE) ? k + LEN_W'(1) : '0;

  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < MAX_SEG; i++)
      if (seg_sel == LEN_W'(i)) seg = snake_q[i*SEG_W +: SEG_W];
  end

  // Outputs are registered: the next-state logic also produces the write
  // that will be on the bus while the machine sits in the next state.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    overrun_n = overrun;
    capture   = 1'b0;
    k_n       = k;
    wr_en_n   = 1'b0;
    done_n    = 1'b0;
    x_n       = wr_x;
    y_n       = wr_y;
    data_n    = wr_data;

    case (state)
      IDLE: begin
        if (tick || pending) begin
          capture   = 1'b1;
          pending_n = 1'b0;
          state_n   = CLEAR;
          wr_en_n   = 1'b1;
          x_n       = '0;
          y_n       = '0;
          data_n    = 2'b00;
        end
      end
      CLEAR: begin
        wr_en_n = 1'b1;
        data_n  = 2'b00;
        if (wr_x == X_LAST) begin
          x_n = '0;
          if (wr_y == Y_LAST) begin
            state_n = FOOD;
            x_n     = xf_q;
            y_n     = yf_q;
            data_n  = 2'b11;
          end else begin
            y_n = wr_y + 1'b1;
          end
        end else begin
          x_n = wr_x + 1'b1;
        end
      end
      FOOD: begin
        if (len_q != '0) begin
          state_n = SNAKE;
          wr_en_n = 1'b1;
          k_n     = '0;
          x_n     = seg[SEG_W-1:COORD_W];
          y_n     = seg[COORD_W-1:0];
          data_n  = 2'b10;
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      SNAKE: begin
        if (k == len_q - LEN_W'(1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          k_n     = k + LEN_W'(1);
          wr_en_n = 1'b1;
          x_n     = seg[SEG_W-1:COORD_W];
          y_n     = seg[COORD_W-1:0];
          data_n  = 2'b01;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // One tick may wait while busy; a second one is lost.
    if (state != IDLE && tick) begin
      if (!pending) pending_n = 1'b1;
      else          overrun_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      overrun <= 1'b0;
      k       <= '0;
      wr_en   <= 1'b0;
      wr_x    <= '0;
      wr_y    <= '0;
      wr_data <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      overrun <= overrun_n;
      k       <= k_n;
      wr_en   <= wr_en_n;
      wr_x    <= x_n;
      wr_y    <= y_n;
      wr_data <= data_n;
      busy    <= (state_n != IDLE);
      done    <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snake_q <= '0;
      len_q   <= '0;
      xf_q    <= '0;
      yf_q    <= '0;
    end else if (capture) begin
      snake_q <= snake;
      len_q   <= (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
      xf_q    <= xfood;
      yf_q    <= yfood;
    end
  end

endmodule

// File: tb/tb_grid_frame_sequencer.sv
// Scoreboard bench for grid_frame_sequencer: each accepted tick pushes the
// full expected write list of its frame (plus a done marker) and its busy
// length; a negedge monitor pops and compares as the DUT emits them.
module tb_grid_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [79:0] snake;
  logic [3:0]  snake_len;
  logic [3:0]  xfood, yfood;
  logic        wr_en, busy, done, overrun;
  logic [3:0]  wr_x, wr_y;
  logic [1:0]  wr_data;

  grid_frame_sequencer #(.GRID_W(16), .GRID_H(16), .MAX_SEG(10), .COORD_W(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .snake(snake), .snake_len(snake_len),
    .xfood(xfood), .yfood(yfood), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_done;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] d;
  } ev_t;

  ev_t evq[$];
  int  lenq[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  run_len = 0;

  // Timing model: a frame accepted at edge s keeps the DUT busy until edge s+L.
  int  m_start = 0, m_L = 0, m_pend_L = 0;
  bit  m_pending = 0, m_overrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int push_frame(input logic [79:0] s, input logic [3:0] len,
                                    input logic [3:0] fx, input logic [3:0] fy);
    int n;
    logic [79:0] sh;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        evq.push_back('{1'b0, 4'(xx), 4'(yy), 2'b00});
    evq.push_back('{1'b0, fx, fy, 2'b11});
    n = (len > 10) ? 10 : int'(len);
    for (int k = 0; k < n; k++) begin
      sh = s >> (8 * k);
      evq.push_back('{1'b0, sh[7:4], sh[3:0], (k == 0) ? 2'b10 : 2'b01});
    end
    evq.push_back('{1'b1, 4'd0, 4'd0, 2'b00});
    lenq.push_back(258 + n);
    return 258 + n;
  endfunction

  task automatic issue_tick();
    int e, L;
    e = cyc + 1;
    if (m_pending && e > m_start + m_L + 1) begin
      m_start   = m_start + m_L + 1;
      m_L       = m_pend_L;
      m_pending = 0;
    end
    if (!m_pending && e >= m_start + m_L) begin
      L = push_frame(snake, snake_len, xfood, yfood);
      m_start = e;
      m_L     = L;
    end else if (!m_pending) begin
      m_pend_L  = push_frame(snake, snake_len, xfood, yfood);
      m_pending = 1;
    end else begin
      m_overrun = 1;
    end
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int endc;
    endc = m_pending ? m_start + m_L + 1 + m_pend_L : m_start + m_L;
    while (cyc < endc + 3) @(posedge clk);
    #1;
    check("writes_outstanding", evq.size(), 0);
    check("frames_outstanding", lenq.size(), 0);
  endtask

  task automatic rand_inputs();
    snake     = {16'($urandom), $urandom, $urandom};
    snake_len = 4'($urandom_range(0, 15));
    xfood     = 4'($urandom);
    yfood     = 4'($urandom);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else begin
      if (wr_en || done) begin
        if (evq.size() == 0) begin
          check("unexpected_output", {wr_en, done}, 2'b00);
        end else begin
          ev_t ex;
          ex = evq.pop_front();
          check("kind", {30'd0, wr_en, done}, ex.is_done ? 32'd1 : 32'd2);
          if (wr_en && !ex.is_done)
            check("write_xyd", {22'd0, wr_x, wr_y, wr_data}, {22'd0, ex.x, ex.y, ex.d});
        end
      end
      if (busy) run_len++;
      else if (run_len > 0) begin
        if (lenq.size() == 0) check("unexpected_busy", run_len, 0);
        else check("busy_len", run_len, lenq.pop_front());
        run_len = 0;
      end
    end
  end

  initial begin
    reset = 1'b1; tick = 1'b0;
    snake = '0; snake_len = '0; xfood = '0; yfood = '0;
    wait_cycles(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_x", wr_x, 0);
    check("rst_wr_y", wr_y, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    wait_cycles(2);

    // Directed frame: three segments, food (9,2)
    snake = '0; snake[23:0] = {8'h35, 8'h45, 8'h55};
    snake_len = 4'd3; xfood = 4'd9; yfood = 4'd2;
    issue_tick();
    check("first_write_latency", {wr_en, wr_x, wr_y}, 9'h100);
    settle();

    // Empty snake
    rand_inputs(); snake_len = 4'd0;
    issue_tick(); settle();

    // Length clamp
    rand_inputs(); snake_len = 4'd15;
    issue_tick(); settle();

    // Head on food
    rand_inputs(); snake[7:0] = 8'h77; snake_len = 4'd2; xfood = 4'd7; yfood = 4'd7;
    issue_tick(); settle();

    // Random frames, inputs changed mid-sequence must not leak in
    for (int i = 0; i < 6; i++) begin
      rand_inputs();
      issue_tick();
      wait_cycles($urandom_range(5, 200));
      rand_inputs();
      settle();
    end

    // Pending tick, then a lost tick
    rand_inputs();
    issue_tick();
    wait_cycles(50);
    issue_tick();
    wait_cycles(2);
    check("overrun_after_pending", overrun, {31'd0, m_overrun});
    wait_cycles(20);
    issue_tick();
    wait_cycles(2);
    check("overrun_after_lost", overrun, {31'd0, m_overrun});
    settle();
    check("overrun_sticky", overrun, {31'd0, m_overrun});

    // Reset during CLEAR at write 100
    rand_inputs();
    issue_tick();           // write 1 visible now
    wait_cycles(99);        // write 100 visible now
    check("write100_x", {wr_en, wr_x, wr_y}, {1'b1, 4'd3, 4'd6});
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    evq.delete(); lenq.delete();
    m_start = 0; m_L = 0; m_pending = 0; m_overrun = 0;
    reset = 1'b0;
    check("midrst_overrun", overrun, {31'd0, m_overrun});
    wait_cycles(3);
    check("post_rst_idle", {wr_en, busy}, 0);
    rand_inputs();
    issue_tick();
    check("restart_origin", {wr_en, wr_x, wr_y}, 9'h100);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
